// File: rtl/diff_in_pkg.sv
// Shared definitions for the differential-input lock monitor.
package diff_in_pkg;

  localparam int STATE_W = 2;

  // Encoding is visible on the STATE port, so values are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_ACQ    = 2'b01,
    ST_LOCKED = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

endpackage

// File: rtl/diff_in_sync.sv
// Dual-leg synchroniser: brings the true and complement legs of a
// differential input buffer into the sampling clock domain.
module diff_in_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_di,
  input  logic i_dib,
  output logic o_s_di,
  output logic o_s_dib
);

  logic [STAGES-1:0] r_di_sync;
  logic [STAGES-1:0] r_dib_sync;

  // Shift each leg through its own flop chain; both chains reset to 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_di_sync  <= '0;
      r_dib_sync <= '0;
    end else begin
      r_di_sync  <= {r_di_sync[STAGES-2:0], i_di};
      r_dib_sync <= {r_dib_sync[STAGES-2:0], i_dib};
    end
  end

  assign o_s_di  = r_di_sync[STAGES-1];
  assign o_s_dib = r_dib_sync[STAGES-1];

endmodule

// File: rtl/diff_in_lock_monitor.sv
// Differential input lock monitor: checks that the two legs stay
// complementary, qualifies edge activity and reports lock, loss-of-signal
// and sticky fault. i_rst asserts asynchronously; the reset generator is
// expected to release it synchronously to i_clk.
module diff_in_lock_monitor
  import diff_in_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_EDGES   = 16,
  parameter int LOS_CYCLES   = 256,
  parameter int FAULT_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_di,
  input  logic               i_dib,
  input  logic               i_clr,
  output logic               o_data,
  output logic               o_locked,
  output logic               o_los,
  output logic               o_fault,
  output logic [STATE_W-1:0] o_state,
  output logic [CNT_W-1:0]   o_edge_cnt
);

  localparam int INV_W = $clog2(FAULT_CYCLES + 1);
  localparam int LOS_W = $clog2(LOS_CYCLES + 1);
  localparam int ACQ_W = $clog2(LOCK_EDGES + 1);

  localparam logic [INV_W-1:0] INV_MAX = INV_W'(FAULT_CYCLES);
  localparam logic [INV_W-1:0] INV_HIT = INV_W'(FAULT_CYCLES - 1);
  localparam logic [LOS_W-1:0] LOS_MAX = LOS_W'(LOS_CYCLES);
  localparam logic [LOS_W-1:0] LOS_HIT = LOS_W'(LOS_CYCLES - 1);
  localparam logic [ACQ_W-1:0] ACQ_MAX = ACQ_W'(LOCK_EDGES);

  logic             w_s_di;
  logic             w_s_dib;
  logic             w_valid;
  logic             w_edge_det;
  logic             w_fault_hit;
  logic             w_los_hit;
  logic             w_lock_hit;
  logic [INV_W-1:0] w_inv_nxt;
  logic [LOS_W-1:0] w_los_nxt;
  logic [ACQ_W-1:0] w_acq_upd;
  state_t           w_state_nxt;

  state_t           r_state;
  logic             r_data;
  logic             r_edge;
  logic [INV_W-1:0] r_inv_cnt;
  logic [LOS_W-1:0] r_los_tmr;
  logic [ACQ_W-1:0] r_acq_cnt;
  logic [CNT_W-1:0] r_edge_cnt;

  diff_in_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_di    (i_di),
    .i_dib   (i_dib),
    .o_s_di  (w_s_di),
    .o_s_dib (w_s_dib)
  );

  // A pair is valid only while the legs disagree; an edge is a valid value
  // that differs from the last valid value, so invalid gaps never fake edges.
  assign w_valid    = w_s_di ^ w_s_dib;
  assign w_edge_det = i_en & w_valid & (w_s_di != r_data);

  // Saturating next values and the "counter is about to reach its limit"
  // conditions, so transitions land on the same edge the counter hits.
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_inv_nxt = '0;
    w_los_nxt = '0;
    w_acq_upd = r_acq_cnt;
    if (!w_valid) begin
      w_inv_nxt = (r_inv_cnt == INV_MAX) ? INV_MAX : r_inv_cnt + INV_W'(1);
    end
    if (!r_edge) begin
      w_los_nxt = (r_los_tmr == LOS_MAX) ? LOS_MAX : r_los_tmr + LOS_W'(1);
    end
    w_fault_hit = !w_valid && (r_inv_cnt >= INV_HIT);
    w_los_hit   = !r_edge && (r_los_tmr >= LOS_HIT);
    if (!w_valid || w_los_hit) begin
      w_acq_upd = '0;
    end else if (r_edge && (r_acq_cnt != ACQ_MAX)) begin
      w_acq_upd = r_acq_cnt + ACQ_W'(1);
    end
    w_lock_hit = r_edge && (w_acq_upd == ACQ_MAX);
  end

  // Next-state logic; priority: disable, fault, loss-of-signal, lock.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:   w_state_nxt = ST_ACQ;
        ST_FAULT:  if (i_clr) w_state_nxt = ST_ACQ;
        ST_ACQ: begin
          if (w_fault_hit)     w_state_nxt = ST_FAULT;
          else if (w_lock_hit) w_state_nxt = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (w_fault_hit)     w_state_nxt = ST_FAULT;
          else if (w_los_hit)  w_state_nxt = ST_ACQ;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Data hold and registered edge strobe; DATA freezes while disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_edge <= w_edge_det;
      if (i_en && w_valid) r_data <= w_s_di;
    end
  end

  // Supervision counters; all cleared while disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inv_cnt  <= '0;
      r_los_tmr  <= '0;
      r_acq_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (!i_en) begin
      r_inv_cnt  <= '0;
      r_los_tmr  <= '0;
      r_acq_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_inv_cnt <= w_inv_nxt;
      r_los_tmr <= w_los_nxt;
      r_acq_cnt <= (r_state == ST_ACQ && w_state_nxt == ST_ACQ) ? w_acq_upd : '0;
      if (w_state_nxt != ST_LOCKED) begin
        r_edge_cnt <= '0;
      end else if (r_state == ST_LOCKED && r_edge && (r_edge_cnt != '1)) begin
        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
      end
    end
  end

  assign o_data     = r_data;
  assign o_locked   = (r_state == ST_LOCKED);
  assign o_fault    = (r_state == ST_FAULT);
  assign o_los      = (r_los_tmr == LOS_MAX) &&
                      (r_state == ST_ACQ || r_state == ST_LOCKED);
  assign o_state    = r_state;
  assign o_edge_cnt = r_edge_cnt;

endmodule

// File: tb/tb_diff_in_lock_monitor.sv
// Self-checking bench for diff_in_lock_monitor: directed scenarios plus a
// randomized run, every cycle compared against a behavioural model.
module tb_diff_in_lock_monitor;

  localparam int SYNC_STAGES  = 2;
  localparam int LOCK_EDGES   = 16;
  localparam int LOS_CYCLES   = 256;
  localparam int FAULT_CYCLES = 4;
  localparam int CNT_W        = 4;
  localparam int ECNT_MAX     = (1 << CNT_W) - 1;

  localparam int S_IDLE = 0, S_ACQ = 1, S_LOCKED = 2, S_FAULT = 3;

  logic             clk = 1'b0;
  logic             rst, en, di, dib, clr;
  logic             o_data, o_locked, o_los, o_fault;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_edge_cnt;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";
  bit    cur_di = 1'b0;

  // Model state: pins seen through a delay line, everything else plain ints.
  bit q_di[$];
  bit q_dib[$];
  int m_state, m_inv, m_los, m_acq, m_ecnt;
  bit m_data, m_edge;

  diff_in_lock_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .LOCK_EDGES  (LOCK_EDGES),
    .LOS_CYCLES  (LOS_CYCLES),
    .FAULT_CYCLES(FAULT_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_di       (di),
    .i_dib      (dib),
    .i_clr      (clr),
    .o_data     (o_data),
    .o_locked   (o_locked),
    .o_los      (o_los),
    .o_fault    (o_fault),
    .o_state    (o_state),
    .o_edge_cnt (o_edge_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    q_di.delete();
    q_dib.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      q_di.push_back(1'b0);
      q_dib.push_back(1'b0);
    end
    m_state = S_IDLE; m_inv = 0; m_los = 0; m_acq = 0; m_ecnt = 0;
    m_data = 1'b0; m_edge = 1'b0;
  endtask

  // One clock of the behavioural rules, evaluated from the pre-edge state.
  task automatic model_step();
    bit s, valid, e, los_hit, fault_hit, lock_hit;
    int ns, inv_n, los_n, acq_n;
    s     = q_di[0];
    valid = q_di[0] ^ q_dib[0];
    e     = m_edge;
    ns    = m_state;
    if (!en) begin
      ns = S_IDLE;
      m_inv = 0; m_los = 0; m_acq = 0; m_ecnt = 0;
    end else begin
      inv_n     = valid ? 0 : min2(m_inv + 1, FAULT_CYCLES);
      los_n     = e ? 0 : min2(m_los + 1, LOS_CYCLES);
      fault_hit = (inv_n == FAULT_CYCLES);
      los_hit   = (los_n == LOS_CYCLES);
      acq_n     = (!valid || los_hit) ? 0 : (e ? m_acq + 1 : m_acq);
      lock_hit  = e && (acq_n >= LOCK_EDGES);
      if (m_state == S_IDLE) ns = S_ACQ;
      else if (m_state == S_FAULT) ns = clr ? S_ACQ : S_FAULT;
      else if (fault_hit) ns = S_FAULT;
      else if (m_state == S_LOCKED && los_hit) ns = S_ACQ;
      else if (m_state == S_ACQ && lock_hit) ns = S_LOCKED;
      m_acq = (m_state == S_ACQ && ns == S_ACQ) ? acq_n : 0;
      if (ns != S_LOCKED) m_ecnt = 0;
      else if (m_state == S_LOCKED && e) m_ecnt = min2(m_ecnt + 1, ECNT_MAX);
      m_inv = inv_n;
      m_los = los_n;
    end
    m_state = ns;
    m_edge  = en && valid && (s != m_data);
    if (en && valid) m_data = s;
    void'(q_di.pop_front());
    void'(q_dib.pop_front());
    q_di.push_back(di);
    q_dib.push_back(dib);
  endtask

  task automatic check_all();
    bit exp_los;
    exp_los = (m_los == LOS_CYCLES) && (m_state == S_ACQ || m_state == S_LOCKED);
    check({phase, ".state"},    32'(o_state),    32'(m_state));
    check({phase, ".data"},     32'(o_data),     32'(m_data));
    check({phase, ".locked"},   32'(o_locked),   32'(m_state == S_LOCKED));
    check({phase, ".fault"},    32'(o_fault),    32'(m_state == S_FAULT));
    check({phase, ".los"},      32'(o_los),      32'(exp_los));
    check({phase, ".edge_cnt"}, 32'(o_edge_cnt), 32'(m_ecnt));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic toggle_edge(input int period);
    cur_di = ~cur_di;
    di  = cur_di;
    dib = ~cur_di;
    repeat (period) cycle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".state"},    32'(o_state),    32'd0);
    check({tag, ".data"},     32'(o_data),     32'd0);
    check({tag, ".locked"},   32'(o_locked),   32'd0);
    check({tag, ".los"},      32'(o_los),      32'd0);
    check({tag, ".fault"},    32'(o_fault),    32'd0);
    check({tag, ".edge_cnt"}, 32'(o_edge_cnt), 32'd0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lock_up(input string tag);
    for (int k = 0; k < 3 * LOCK_EDGES && !o_locked; k++) toggle_edge(8);
    check({tag, ".lock_reached"}, 32'(o_locked), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; di = 1'b0; dib = 1'b1; cur_di = 1'b0;
    model_reset();

    // 1: reset, then disabled toggling keeps everything at zero
    phase = "s1";
    repeat (3) @(negedge clk);
    check_zero("s1_in_reset");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) toggle_edge(5);
    check("s1_idle_state", 32'(o_state), 32'd0);
    check("s1_idle_data",  32'(o_data),  32'd0);

    // 2: clean toggling every 8 cycles acquires lock
    phase = "s2";
    en = 1'b1;
    repeat (4) cycle();
    lock_up("s2");
    check("s2_state", 32'(o_state), 32'(S_LOCKED));

    // 3: activity stops -> loss-of-signal drops back to ACQ
    phase = "s3";
    for (int k = 0; k < LOS_CYCLES + 20 && !o_los; k++) cycle();
    check("s3_los",      32'(o_los),      32'd1);
    check("s3_state",    32'(o_state),    32'(S_ACQ));
    check("s3_edge_cnt", 32'(o_edge_cnt), 32'd0);

    // 4: three invalid cycles are tolerated, four latch a sticky fault
    phase = "s4";
    lock_up("s4");
    di = 1'b1; dib = 1'b1;
    repeat (3) cycle();
    di = cur_di; dib = ~cur_di;
    cycle();
    check("s4_data_held", 32'(o_data),  32'(cur_di));
    repeat (4) cycle();
    check("s4_no_fault",  32'(o_fault), 32'd0);
    check("s4_still_lck", 32'(o_state), 32'(S_LOCKED));
    di = 1'b1; dib = 1'b1;
    repeat (4) cycle();
    di = cur_di; dib = ~cur_di;
    repeat (3) cycle();
    check("s4_fault",       32'(o_fault), 32'd1);
    check("s4_fault_state", 32'(o_state), 32'(S_FAULT));
    repeat (10) cycle();
    check("s4_sticky", 32'(o_state), 32'(S_FAULT));
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("s4_clr_to_acq", 32'(o_state), 32'(S_ACQ));

    // 5: edge counter saturates, then reset mid-LOCKED
    phase = "s5";
    lock_up("s5");
    for (int k = 0; k < 20; k++) toggle_edge(4);
    check("s5_edge_sat", 32'(o_edge_cnt), 32'(ECNT_MAX));
    check("s5_pre_rst",  32'(o_locked),   32'd1);
    async_reset("s5_rst");

    // 6: an invalid cycle restarts acquisition
    phase = "s6";
    repeat (4) cycle();
    for (int k = 0; k < 8; k++) toggle_edge(8);
    di = 1'b1; dib = 1'b1;
    cycle();
    di = cur_di; dib = ~cur_di;
    repeat (4) cycle();
    for (int k = 0; k < LOCK_EDGES - 1; k++) toggle_edge(8);
    check("s6_not_yet", 32'(o_locked), 32'd0);
    toggle_edge(8);
    check("s6_locked",  32'(o_locked), 32'd1);

    // 7: randomized traffic against the model
    phase = "rnd";
    for (int it = 0; it < 2500; it++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 150) begin
        toggle_edge(1);
      end else if (r < 155) begin
        di = 1'($urandom_range(0, 1)); dib = di;
        repeat ($urandom_range(1, 6)) cycle();
        di = cur_di; dib = ~cur_di;
        cycle();
      end else if (r < 160) begin
        clr = 1'b1; cycle(); clr = 1'b0;
      end else if (r < 163) begin
        en = 1'b0; repeat ($urandom_range(1, 5)) cycle(); en = 1'b1;
      end else if (r < 164) begin
        async_reset("rnd_rst");
      end else if (r < 167) begin
        repeat (LOS_CYCLES + 10) cycle();
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
